// File: rtl/conv2d_ctrl.sv
// conv2d_ctrl: sequences one full 2-D convolution pass over external input,
// kernel and bias memories, one multiply-accumulate tap per cycle, and writes
// each saturated result through a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one tap read per cycle for the current output
// DRAIN | last tap's data arrives, final accumulate
// WRITE | result presented, held until out_ready
// DONE  | one-cycle completion pulse

module conv2d_ctrl #(
    parameter int in_channels  = 1,
    parameter int out_channels = 1,
    parameter int rows         = 28,
    parameter int cols         = 28,
    parameter int kernel_rows  = 3,
    parameter int kernel_cols  = 3,
    parameter int stride       = 1,
    parameter int pad          = 0,
    parameter int data_size    = 8,
    localparam int OR   = (rows + 2*pad - kernel_rows)/stride + 1,
    localparam int OC   = (cols + 2*pad - kernel_cols)/stride + 1,
    localparam int T    = in_channels*kernel_rows*kernel_cols,
    localparam int NI   = in_channels*rows*cols,
    localparam int NK   = in_channels*out_channels*kernel_rows*kernel_cols,
    localparam int NO   = out_channels*OR*OC,
    localparam int AW_I = (NI > 1) ? $clog2(NI) : 1,
    localparam int AW_K = (NK > 1) ? $clog2(NK) : 1,
    localparam int AW_O = (NO > 1) ? $clog2(NO) : 1,
    localparam int BW   = (out_channels > 1) ? $clog2(out_channels) : 1,
    localparam int ACCW = 2*data_size + $clog2(T+1) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        in_en,
    output logic [AW_I-1:0]             in_addr,
    input  logic signed [data_size-1:0] in_data,
    output logic                        kern_en,
    output logic [AW_K-1:0]             kern_addr,
    input  logic signed [data_size-1:0] kern_data,
    output logic [BW-1:0]               bias_addr,
    input  logic signed [data_size-1:0] bias_data,
    output logic                        out_valid,
    output logic [AW_O-1:0]             out_addr,
    output logic signed [data_size-1:0] out_data,
    input  logic                        out_ready
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    localparam int CW = 16;
    localparam logic signed [ACCW-1:0] SMAX = (ACCW'(1) <<< (data_size-1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] SMIN = -SMAX - ACCW'(1);

    state_t state, state_nx;

    logic [CW-1:0]            co, r, c, ci, kr, kc;
    logic signed [ACCW-1:0]   acc;
    logic                     tap_v, tap_first, tap_in;
    logic signed [31:0]       ir, ic;
    logic                     tap_inside, last_tap, last_out;
    logic [AW_I-1:0]          ia;
    logic [AW_K-1:0]          ka;
    logic [AW_O-1:0]          oa;
    logic signed [2*data_size-1:0] prod;
    logic signed [ACCW-1:0]   prod_x, bias_x, acc_base;
    logic [data_size-1:0]     sat;

    // Tap coordinates in the unpadded map; negative or past-edge means padding.
    assign ir = 32'(r) * 32'(stride) + 32'(kr) - 32'(pad);
    assign ic = 32'(c) * 32'(stride) + 32'(kc) - 32'(pad);
    assign tap_inside = (ir >= 0) && (ir < rows) && (ic >= 0) && (ic < cols);

    assign ia = AW_I'(32'(ci) * 32'(rows*cols) + 32'(ir) * 32'(cols) + 32'(ic));
    assign ka = AW_K'(((32'(ci) * 32'(out_channels) + 32'(co)) * 32'(kernel_rows) + 32'(kr))
                      * 32'(kernel_cols) + 32'(kc));
    assign oa = AW_O'(32'(co) * 32'(OR*OC) + 32'(r) * 32'(OC) + 32'(c));

    assign last_tap = (ci == CW'(in_channels-1)) && (kr == CW'(kernel_rows-1))
                   && (kc == CW'(kernel_cols-1));
    assign last_out = (co == CW'(out_channels-1)) && (r == CW'(OR-1)) && (c == CW'(OC-1));

    // Product of the tap issued last cycle; padded taps contribute zero.
    always_comb begin
        prod = '0;
        if (tap_in) begin
            prod = in_data * kern_data;
        end
        prod_x   = prod;
        bias_x   = bias_data;
        acc_base = tap_first ? bias_x : acc;
    end

    // Clamp the accumulator to the signed result range.
    always_comb begin
        sat = acc[data_size-1:0];
        if (acc > SMAX) begin
            sat = SMAX[data_size-1:0];
        end else if (acc < SMIN) begin
            sat = SMIN[data_size-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        in_en     = 1'b0;
        kern_en   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ISSUE;
            end
            ISSUE: begin
                busy    = 1'b1;
                kern_en = 1'b1;
                in_en   = tap_inside;
                if (last_tap) state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = last_out ? DONE : ISSUE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Addresses and data are forced to zero whenever their strobe is low.
    assign in_addr   = in_en ? ia : '0;
    assign kern_addr = kern_en ? ka : '0;
    assign bias_addr = co[BW-1:0];
    assign out_addr  = out_valid ? oa : '0;
    assign out_data  = out_valid ? sat : '0;

    // Loop counters, read-response pipeline flags and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            co        <= '0;
            r         <= '0;
            c         <= '0;
            ci        <= '0;
            kr        <= '0;
            kc        <= '0;
            acc       <= '0;
            tap_v     <= 1'b0;
            tap_first <= 1'b0;
            tap_in    <= 1'b0;
        end else begin
            tap_v     <= (state == ISSUE);
            tap_first <= (state == ISSUE) && (ci == '0) && (kr == '0) && (kc == '0);
            tap_in    <= in_en;
            if (tap_v) begin
                acc <= acc_base + prod_x;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        co <= '0;
                        r  <= '0;
                        c  <= '0;
                        ci <= '0;
                        kr <= '0;
                        kc <= '0;
                    end
                end
                ISSUE: begin
                    if (kc == CW'(kernel_cols-1)) begin
                        kc <= '0;
                        if (kr == CW'(kernel_rows-1)) begin
                            kr <= '0;
                            if (ci == CW'(in_channels-1)) begin
                                ci <= '0;
                            end else begin
                                ci <= ci + CW'(1);
                            end
                        end else begin
                            kr <= kr + CW'(1);
                        end
                    end else begin
                        kc <= kc + CW'(1);
                    end
                end
                WRITE: begin
                    if (out_ready) begin
                        if (c == CW'(OC-1)) begin
                            c <= '0;
                            if (r == CW'(OR-1)) begin
                                r <= '0;
                                if (co == CW'(out_channels-1)) begin
                                    co <= '0;
                                end else begin
                                    co <= co + CW'(1);
                                end
                            end else begin
                                r <= r + CW'(1);
                            end
                        end else begin
                            c <= c + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
